// File: rtl/lime_io_bridge.sv
// Host I/O stage for the 16-bit core: loads an operand, runs the core, captures its result or times out.
// Latency: operand on edge T, core released after T+1, result valid after the edge that samples proc_out_we.
// Backpressure: one transaction in flight; in_ready low until the host takes the result via res_ready.
module lime_io_bridge #(
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 1000,
    parameter int CNT_W       = 16
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] main_input,
    output logic              proc_rst_n,
    input  logic [DATA_W-1:0] main_output,
    input  logic              proc_out_we,
    output logic [DATA_W-1:0] res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_timeout,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] main_input_nxt, res_data_nxt;
    logic              proc_rst_n_nxt, res_valid_nxt, res_timeout_nxt;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            main_input  <= '0;
            proc_rst_n  <= 1'b0;
            res_data    <= '0;
            res_valid   <= 1'b0;
            res_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            main_input  <= main_input_nxt;
            proc_rst_n  <= proc_rst_n_nxt;
            res_data    <= res_data_nxt;
            res_valid   <= res_valid_nxt;
            res_timeout <= res_timeout_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        main_input_nxt  = main_input;
        proc_rst_n_nxt  = proc_rst_n;
        res_data_nxt    = res_data;
        res_valid_nxt   = res_valid;
        res_timeout_nxt = res_timeout;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    main_input_nxt = in_data;
                    state_nxt      = LOAD;
                end
            end
            LOAD: begin
                // Operand has been stable for a full cycle before the core leaves reset.
                proc_rst_n_nxt = 1'b1;
                cnt_nxt        = '0;
                state_nxt      = RUN;
            end
            RUN: begin
                cnt_nxt = cnt + 1'b1;
                // A real strobe beats a coincident timeout.
                if (proc_out_we || cnt == CNT_LAST) begin
                    res_data_nxt    = main_output;
                    res_valid_nxt   = 1'b1;
                    res_timeout_nxt = !proc_out_we;
                    proc_rst_n_nxt  = 1'b0;
                    state_nxt       = DONE;
                end
            end
            DONE: begin
                if (res_valid && res_ready) begin
                    res_valid_nxt   = 1'b0;
                    res_timeout_nxt = 1'b0;
                    state_nxt       = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_lime_io_bridge.sv
// Directed bench: dut_a uses the default timeout, dut_b a 16-cycle timeout.
module tb_lime_io_bridge;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic [15:0] in_data;
    logic        in_valid_a, in_valid_b;
    logic [15:0] main_output;
    logic        proc_out_we;
    logic        res_ready;

    logic        a_in_ready, a_proc_rst_n, a_res_valid, a_res_timeout, a_busy;
    logic [15:0] a_main_input, a_res_data;
    logic        b_in_ready, b_proc_rst_n, b_res_valid, b_res_timeout, b_busy;
    logic [15:0] b_main_input, b_res_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    lime_io_bridge dut_a (
        .CLK(CLK), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid_a),
        .in_ready(a_in_ready), .main_input(a_main_input), .proc_rst_n(a_proc_rst_n),
        .main_output(main_output), .proc_out_we(proc_out_we), .res_data(a_res_data),
        .res_valid(a_res_valid), .res_ready(res_ready), .res_timeout(a_res_timeout),
        .busy(a_busy)
    );

    lime_io_bridge #(.TIMEOUT_CYC(16)) dut_b (
        .CLK(CLK), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid_b),
        .in_ready(b_in_ready), .main_input(b_main_input), .proc_rst_n(b_proc_rst_n),
        .main_output(main_output), .proc_out_we(proc_out_we), .res_data(b_res_data),
        .res_valid(b_res_valid), .res_ready(res_ready), .res_timeout(b_res_timeout),
        .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Core model for dut_a: strobes its result lat cycles after release.
    task automatic txn_a(input logic [15:0] op, input int lat, input logic [15:0] exp_res);
        in_data    = op;
        in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        check("acc_main_input", a_main_input, op);
        check("acc_busy", a_busy, 1);
        check("acc_in_ready", a_in_ready, 0);
        check("load_proc_rst_n", a_proc_rst_n, 0);
        step();
        check("release_proc_rst_n", a_proc_rst_n, 1);
        repeat (lat - 1) step();
        check("pre_res_valid", a_res_valid, 0);
        proc_out_we = 1'b1;
        main_output = exp_res;
        step();
        proc_out_we = 1'b0;
        main_output = 16'h0000;
        check("res_valid", a_res_valid, 1);
        check("res_data", a_res_data, exp_res);
        check("res_timeout", a_res_timeout, 0);
        check("done_proc_rst_n", a_proc_rst_n, 0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("ack_res_valid", a_res_valid, 0);
        check("ack_in_ready", a_in_ready, 1);
    endtask

    initial begin
        reset_n     = 1'b0;
        in_data     = 16'h0000;
        in_valid_a  = 1'b0;
        in_valid_b  = 1'b0;
        main_output = 16'h0000;
        proc_out_we = 1'b0;
        res_ready   = 1'b0;
        step();
        step();
        check("rst_main_input", a_main_input, 0);
        check("rst_proc_rst_n", a_proc_rst_n, 0);
        check("rst_res_data", a_res_data, 0);
        check("rst_res_valid", a_res_valid, 0);
        check("rst_res_timeout", a_res_timeout, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_busy", a_busy, 0);
        reset_n = 1'b1;
        step();

        // Reset while running
        in_data    = 16'h0042;
        in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        step();
        step();
        step();
        check("mid_busy", a_busy, 1);
        check("mid_proc_rst_n", a_proc_rst_n, 1);
        reset_n = 1'b0;
        #1;
        check("arst_proc_rst_n", a_proc_rst_n, 0);
        check("arst_res_valid", a_res_valid, 0);
        check("arst_main_input", a_main_input, 0);
        check("arst_in_ready", a_in_ready, 1);
        check("arst_busy", a_busy, 0);
        step();
        reset_n = 1'b1;
        step();

        // Nominal transaction, 40-cycle core latency
        txn_a(16'h0006, 40, 16'h0005);

        // Spurious strobe in IDLE, then back-to-back operands
        proc_out_we = 1'b1;
        main_output = 16'hDEAD;
        step();
        proc_out_we = 1'b0;
        main_output = 16'h0000;
        check("spur_res_valid", a_res_valid, 0);
        check("spur_busy", a_busy, 0);
        txn_a(16'h0006, 5, 16'h0005);
        txn_a(16'h0010, 7, 16'h0003);
        check("b2b_main_input_held", a_main_input, 16'h0010);

        // Timeout on dut_b
        in_data    = 16'h0009;
        in_valid_b = 1'b1;
        step();
        in_valid_b = 1'b0;
        step();
        main_output = 16'h1234;
        repeat (15) step();
        check("to_pre_res_valid", b_res_valid, 0);
        step();
        check("to_res_valid", b_res_valid, 1);
        check("to_res_timeout", b_res_timeout, 1);
        check("to_res_data", b_res_data, 16'h1234);
        check("to_proc_rst_n", b_proc_rst_n, 0);
        main_output = 16'h0000;
        res_ready   = 1'b1;
        step();
        res_ready = 1'b0;
        check("to_ack_res_valid", b_res_valid, 0);
        check("to_ack_res_timeout", b_res_timeout, 0);

        // Strobe coincides with the last timeout cycle
        in_data    = 16'h0007;
        in_valid_b = 1'b1;
        step();
        in_valid_b = 1'b0;
        step();
        repeat (15) step();
        proc_out_we = 1'b1;
        main_output = 16'h00AB;
        step();
        proc_out_we = 1'b0;
        main_output = 16'h0000;
        check("col_res_valid", b_res_valid, 1);
        check("col_res_data", b_res_data, 16'h00AB);
        check("col_res_timeout", b_res_timeout, 0);

        // Host backpressure with a competing operand offered
        in_valid_b = 1'b1;
        in_data    = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_res_valid", b_res_valid, 1);
            check("bp_res_data", b_res_data, 16'h00AB);
            check("bp_in_ready", b_in_ready, 0);
            check("bp_main_input", b_main_input, 16'h0007);
        end
        in_valid_b = 1'b0;
        res_ready  = 1'b1;
        step();
        res_ready = 1'b0;
        check("bp_ack_res_valid", b_res_valid, 0);
        check("bp_ack_in_ready", b_in_ready, 1);
        check("bp_ack_res_data", b_res_data, 16'h00AB);
        check("bp_ack_main_input", b_main_input, 16'h0007);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
